// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V constants plus load-path types and request-decode helpers.
`default_nettype none

package riscv_pkg;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } load_state_e;

   // True for illegal load encodings and for accesses not aligned to their size.
   function automatic logic ld_fault(input logic [1:0] off, input logic [2:0] f3);
      logic flt;
      flt = 1'b1;
      case (f3)
         FUNCT3_LB, FUNCT3_LBU: flt = 1'b0;
         FUNCT3_LH, FUNCT3_LHU: flt = off[0];
         FUNCT3_LW:             flt = (off != 2'b00);
         default:               flt = 1'b1;
      endcase
      return flt;
   endfunction

   function automatic logic [3:0] ld_be(input logic [1:0] off, input logic [2:0] f3);
      logic [3:0] be;
      be = 4'b0000;
      case (f3)
         FUNCT3_LB, FUNCT3_LBU: be = 4'b0001 << off;
         FUNCT3_LH, FUNCT3_LHU: be = off[1] ? 4'b1100 : 4'b0011;
         FUNCT3_LW:             be = 4'b1111;
         default:               be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

`default_nettype wire

// File: rtl/load_formatter.sv
// load_formatter: combinational byte/halfword extraction and sign/zero extension of a read word.
`default_nettype none

module load_formatter
   import riscv_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = 8'h00;
      case (off_i)
         2'd0: w_byte = rdata_i[7:0];
         2'd1: w_byte = rdata_i[15:8];
         2'd2: w_byte = rdata_i[23:16];
         2'd3: w_byte = rdata_i[31:24];
         default: w_byte = 8'h00;
      endcase
      w_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      data_o = 32'h0000_0000;
      case (funct3_i)
         FUNCT3_LB:  data_o = {{24{w_byte[7]}}, w_byte};
         FUNCT3_LBU: data_o = {24'h000000, w_byte};
         FUNCT3_LH:  data_o = {{16{w_half[15]}}, w_half};
         FUNCT3_LHU: data_o = {16'h0000, w_half};
         FUNCT3_LW:  data_o = rdata_i;
         default:    data_o = 32'h0000_0000;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/load_unit.sv
// load_unit: data-memory load path; issues one word read over req/gnt/rvalid and
// returns an aligned, extended result or a fault (misaligned, illegal funct3, timeout).
`default_nettype none

module load_unit
   import riscv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_funct3,
   output logic        dmem_req,
   input  logic        dmem_gnt,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic        res_fault,
   output logic        busy
);

   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   load_state_e       state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [3:0]        be_q, be_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       res_data_q, res_data_d;
   logic              res_fault_q, res_fault_d;
   logic [31:0]       w_fmt_data;

   load_formatter u_fmt (
      .rdata_i  (dmem_rdata),
      .off_i    (addr_q[1:0]),
      .funct3_i (funct3_q),
      .data_o   (w_fmt_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= 32'h0000_0000;
         funct3_q    <= 3'b000;
         be_q        <= 4'b0000;
         cnt_q       <= '0;
         res_data_q  <= 32'h0000_0000;
         res_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         funct3_q    <= funct3_d;
         be_q        <= be_d;
         cnt_q       <= cnt_d;
         res_data_q  <= res_data_d;
         res_fault_q <= res_fault_d;
      end
   end

   // Result registers only change on the transition into RESP, so they hold between results.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      funct3_d    = funct3_q;
      be_d        = be_q;
      cnt_d       = cnt_q;
      res_data_d  = res_data_q;
      res_fault_d = res_fault_q;

      case (state_q)
         IDLE: begin
            if (ld_valid) begin
               addr_d   = ld_addr;
               funct3_d = ld_funct3;
               if (ld_fault(ld_addr[1:0], ld_funct3)) begin
                  be_d        = 4'b0000;
                  res_data_d  = 32'h0000_0000;
                  res_fault_d = 1'b1;
                  state_d     = RESP;
               end else begin
                  be_d    = ld_be(ld_addr[1:0], ld_funct3);
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (dmem_gnt) begin
               if (dmem_rvalid) begin
                  res_data_d  = w_fmt_data;
                  res_fault_d = 1'b0;
                  state_d     = RESP;
               end else begin
                  cnt_d   = '0;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (dmem_rvalid) begin
               res_data_d  = w_fmt_data;
               res_fault_d = 1'b0;
               state_d     = RESP;
            end else if (cnt_q == C_CNT_LAST) begin
               res_data_d  = 32'h0000_0000;
               res_fault_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ld_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign dmem_req  = (state_q == REQ);
   assign dmem_addr = {addr_q[31:2], 2'b00};
   assign dmem_be   = be_q;
   assign res_valid = (state_q == RESP);
   assign res_data  = res_data_q;
   assign res_fault = res_fault_q;

endmodule

`default_nettype wire
